reset_sequencer: RTL and testbench

//  Parametrised power-on/domain reset sequencer. Generalises the fixed 4-bit clk27 reset counter
//  in the top level. Holds NUM_STAGES reset outputs low, waits until NUM_LOCKS PLL locks are stable,

---
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on/domain reset sequencer: holds all stage resets low, waits for PLL locks, then releases
// stages 0..NUM_STAGES-1 in order STAGE_DELAY cycles apart; sticky per-PLL lock-lost flags.
module reset_sequencer #(
    parameter int NUM_STAGES   = 3,
    parameter int STAGE_DELAY  = 8,
    parameter int CNT_W        = 4,
    parameter int NUM_LOCKS    = 3,
    parameter bit REQUIRE_LOCK = 1'b1
) (
    input  logic                  clk27,
    input  logic                  reset_n,
    input  logic [NUM_LOCKS-1:0]  lock_in,
    input  logic                  sw_rst_req,
    input  logic                  clr_lost,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic [NUM_LOCKS-1:0]  lock_lost,
    output logic                  seq_done,
    output logic [1:0]            state
);

    localparam int IDX_W = $clog2(NUM_STAGES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_rst_n;
    logic                  r_seq_done;
    logic [NUM_LOCKS-1:0]  r_lock_lost;
    logic [NUM_LOCKS-1:0]  r_sync1;
    logic [NUM_LOCKS-1:0]  r_lk;
    logic [NUM_LOCKS-1:0]  r_lk_d;

    logic                  w_all_lk;
    logic                  w_all_lk_d;
    logic                  w_active;
    logic                  w_lock_drop;
    logic                  w_restart;
    logic                  w_cnt_last;
    logic                  w_idx_last;
    logic [NUM_LOCKS-1:0]  w_lk_fall;
    logic [NUM_STAGES-1:0] w_rel_mask;

    // lk_d is the previous synchronised lock level, used for falling-edge detection
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_lk    <= '0;
            r_lk_d  <= '0;
        end else begin
            r_sync1 <= lock_in;
            r_lk    <= r_sync1;
            r_lk_d  <= r_lk;
        end
    end

    assign w_all_lk    = REQUIRE_LOCK ? (&r_lk)   : 1'b1;
    assign w_all_lk_d  = REQUIRE_LOCK ? (&r_lk_d) : 1'b1;
    assign w_active    = (r_state == ST_RELEASE) || (r_state == ST_RUN);
    assign w_lock_drop = REQUIRE_LOCK && w_active && w_all_lk_d && !w_all_lk;
    assign w_restart   = sw_rst_req || w_lock_drop;
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_idx_last  = (r_idx == IDX_LAST);
    assign w_lk_fall   = r_lk_d & ~r_lk;

    always_comb begin
        w_rel_mask = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_idx == IDX_W'(k)) w_rel_mask[k] = 1'b1;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
        end else if (w_restart) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_rst_n <= '0;
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_LOCK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    r_rst_n <= '0;
                    if (w_all_lk) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_cnt_last) begin
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 1'b1;
                        r_rst_n <= r_rst_n | w_rel_mask;
                        if (w_idx_last) begin
                            r_state    <= ST_RUN;
                            r_seq_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rst_n    <= '1;
                    r_seq_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    // A new loss on the same cycle as a clear must survive, so the set term is ORed after clearing
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_lost <= '0;
        end else begin
            r_lock_lost <= (clr_lost ? '0 : r_lock_lost) | (w_active ? w_lk_fall : '0);
        end
    end

    assign rst_n_out = r_rst_n;
    assign lock_lost = r_lock_lost;
    assign seq_done  = r_seq_done;
    assign state     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a REQUIRE_LOCK=0 instance.
module tb_reset_sequencer;

    logic       clk27 = 1'b0;
    logic       reset_n;
    logic [2:0] lock_in;
    logic       sw_rst_req;
    logic       clr_lost;
    logic [2:0] rst_n_out;
    logic [2:0] lock_lost;
    logic       seq_done;
    logic [1:0] state;

    logic       reset_n_b;
    logic [2:0] lock_in_b;
    logic       sw_rst_req_b;
    logic       clr_lost_b;
    logic [2:0] rst_n_out_b;
    logic [2:0] lock_lost_b;
    logic       seq_done_b;
    logic [1:0] state_b;

    int checks = 0;
    int errors = 0;

    always #5 clk27 = ~clk27;

    reset_sequencer dut (
        .clk27      (clk27),
        .reset_n    (reset_n),
        .lock_in    (lock_in),
        .sw_rst_req (sw_rst_req),
        .clr_lost   (clr_lost),
        .rst_n_out  (rst_n_out),
        .lock_lost  (lock_lost),
        .seq_done   (seq_done),
        .state      (state)
    );

    reset_sequencer #(.REQUIRE_LOCK(1'b0)) dut_nolock (
        .clk27      (clk27),
        .reset_n    (reset_n_b),
        .lock_in    (lock_in_b),
        .sw_rst_req (sw_rst_req_b),
        .clr_lost   (clr_lost_b),
        .rst_n_out  (rst_n_out_b),
        .lock_lost  (lock_lost_b),
        .seq_done   (seq_done_b),
        .state      (state_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk27);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; lock_in = 3'b111; sw_rst_req = 1'b0; clr_lost = 1'b0;
        reset_n_b = 1'b0; lock_in_b = 3'b000; sw_rst_req_b = 1'b0; clr_lost_b = 1'b0;
        tick(3);
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL rst_rst_n got %b exp 000", rst_n_out); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL rst_seq_done got %b exp 0", seq_done); end
        checks++; if (lock_lost !== 3'b000) begin errors++; $display("FAIL rst_lock_lost got %b exp 000", lock_lost); end
    endtask

    task automatic test_power_on();
        @(negedge clk27); reset_n = 1'b1;
        tick(7);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL p1_e7_state got %0d exp 0", state); end
        tick(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL p1_e8_state got %0d exp 1", state); end
        tick(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL p1_e9_state got %0d exp 2", state); end
        tick(7);
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p1_e16_rst got %b exp 000", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p1_e17_rst got %b exp 001", rst_n_out); end
        tick(7);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p1_e24_rst got %b exp 001", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b011) begin errors++; $display("FAIL p1_e25_rst got %b exp 011", rst_n_out); end
        tick(7);
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL p1_e32_done got %b exp 0", seq_done); end
        tick(1);
        checks++; if (rst_n_out !== 3'b111) begin errors++; $display("FAIL p1_e33_rst got %b exp 111", rst_n_out); end
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL p1_e33_done got %b exp 1", seq_done); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL p1_e33_state got %0d exp 3", state); end
        checks++; if (lock_lost !== 3'b000) begin errors++; $display("FAIL p1_e33_lost got %b exp 000", lock_lost); end
    endtask

    task automatic test_wait_lock();
        reset_n = 1'b0; lock_in = 3'b011;
        tick(2);
        @(negedge clk27); reset_n = 1'b1;
        tick(40);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL p2_e40_state got %0d exp 1", state); end
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p2_e40_rst got %b exp 000", rst_n_out); end
        lock_in = 3'b111;
        tick(2);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL p2_e42_state got %0d exp 1", state); end
        tick(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL p2_e43_state got %0d exp 2", state); end
        tick(7);
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p2_e50_rst got %b exp 000", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p2_e51_rst got %b exp 001", rst_n_out); end
        tick(16);
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL p2_e67_done got %b exp 1", seq_done); end
    endtask

    task automatic test_lock_drop();
        lock_in = 3'b101;
        tick(2);
        checks++; if (rst_n_out !== 3'b111) begin errors++; $display("FAIL p3_d2_rst got %b exp 111", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p3_d3_rst got %b exp 000", rst_n_out); end
        checks++; if (lock_lost !== 3'b010) begin errors++; $display("FAIL p3_d3_lost got %b exp 010", lock_lost); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL p3_d3_state got %0d exp 0", state); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL p3_d3_done got %b exp 0", seq_done); end
        tick(2);
        lock_in = 3'b111;
        tick(6);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL p3_d11_state got %0d exp 1", state); end
        tick(1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL p3_d12_state got %0d exp 2", state); end
        tick(7);
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p3_d19_rst got %b exp 000", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p3_d20_rst got %b exp 001", rst_n_out); end
        tick(8);
        checks++; if (rst_n_out !== 3'b011) begin errors++; $display("FAIL p3_d28_rst got %b exp 011", rst_n_out); end
        tick(8);
        checks++; if (rst_n_out !== 3'b111) begin errors++; $display("FAIL p3_d36_rst got %b exp 111", rst_n_out); end
        checks++; if (lock_lost !== 3'b010) begin errors++; $display("FAIL p3_d36_lost got %b exp 010", lock_lost); end
        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        checks++; if (lock_lost !== 3'b000) begin errors++; $display("FAIL p3_clr_lost got %b exp 000", lock_lost); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL p3_clr_state got %0d exp 3", state); end
    endtask

    task automatic test_sw_restart();
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p4_run_rst got %b exp 000", rst_n_out); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL p4_run_done got %b exp 0", seq_done); end
        tick(17);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p4_s0_rst got %b exp 001", rst_n_out); end
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p4_rel_rst got %b exp 000", rst_n_out); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL p4_rel_state got %0d exp 0", state); end
        tick(8);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL p4_b8_state got %0d exp 1", state); end
        tick(9);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p4_b17_rst got %b exp 001", rst_n_out); end
        tick(8);
        checks++; if (rst_n_out !== 3'b011) begin errors++; $display("FAIL p4_b25_rst got %b exp 011", rst_n_out); end
        tick(8);
        checks++; if (rst_n_out !== 3'b111) begin errors++; $display("FAIL p4_b33_rst got %b exp 111", rst_n_out); end
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL p4_b33_done got %b exp 1", seq_done); end
    endtask

    task automatic test_back_to_back();
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        tick(32);
        checks++; if (rst_n_out !== 3'b011) begin errors++; $display("FAIL bb_r32_rst got %b exp 011", rst_n_out); end
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL bb_final_state got %0d exp 0", state); end
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL bb_final_rst got %b exp 000", rst_n_out); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL bb_final_done got %b exp 0", seq_done); end
        tick(33);
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL bb_rerun_done got %b exp 1", seq_done); end
        lock_in = 3'b110;
        tick(2);
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        lock_in = 3'b111;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL bb_both_state got %0d exp 0", state); end
        checks++; if (lock_lost !== 3'b001) begin errors++; $display("FAIL bb_both_lost got %b exp 001", lock_lost); end
        tick(7);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL bb_both_d10_state got %0d exp 0", state); end
        tick(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL bb_both_d11_state got %0d exp 1", state); end
        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        checks++; if (lock_lost !== 3'b000) begin errors++; $display("FAIL bb_clr_lost got %b exp 000", lock_lost); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL bb_d12_state got %0d exp 2", state); end
        tick(24);
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL bb_d36_done got %b exp 1", seq_done); end
    endtask

    task automatic test_lost_vs_clear();
        lock_in = 3'b011;
        tick(2);
        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        lock_in = 3'b111;
        checks++; if (lock_lost !== 3'b100) begin errors++; $display("FAIL p6_setwins_lost got %b exp 100", lock_lost); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL p6_setwins_state got %0d exp 0", state); end
        tick(3);
        checks++; if (lock_lost !== 3'b100) begin errors++; $display("FAIL p6_sticky_lost got %b exp 100", lock_lost); end
        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        checks++; if (lock_lost !== 3'b000) begin errors++; $display("FAIL p6_clr_lost got %b exp 000", lock_lost); end
    endtask

    task automatic test_async_reset();
        sw_rst_req = 1'b1;
        tick(1);
        sw_rst_req = 1'b0;
        tick(20);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p5_pre_rst got %b exp 001", rst_n_out); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p5_async_rst got %b exp 000", rst_n_out); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL p5_async_state got %0d exp 0", state); end
        @(negedge clk27); reset_n = 1'b1;
        tick(16);
        checks++; if (rst_n_out !== 3'b000) begin errors++; $display("FAIL p5_e16_rst got %b exp 000", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b001) begin errors++; $display("FAIL p5_e17_rst got %b exp 001", rst_n_out); end
        tick(8);
        checks++; if (rst_n_out !== 3'b011) begin errors++; $display("FAIL p5_e25_rst got %b exp 011", rst_n_out); end
        tick(7);
        checks++; if (rst_n_out !== 3'b011) begin errors++; $display("FAIL p5_e32_rst got %b exp 011", rst_n_out); end
        tick(1);
        checks++; if (rst_n_out !== 3'b111) begin errors++; $display("FAIL p5_e33_rst got %b exp 111", rst_n_out); end
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL p5_e33_done got %b exp 1", seq_done); end
    endtask

    task automatic test_no_lock_req();
        @(negedge clk27); reset_n_b = 1'b1;
        tick(8);
        checks++; if (state_b !== 2'd1) begin errors++; $display("FAIL nl_e8_state got %0d exp 1", state_b); end
        tick(1);
        checks++; if (state_b !== 2'd2) begin errors++; $display("FAIL nl_e9_state got %0d exp 2", state_b); end
        tick(8);
        checks++; if (rst_n_out_b !== 3'b001) begin errors++; $display("FAIL nl_e17_rst got %b exp 001", rst_n_out_b); end
        tick(15);
        checks++; if (seq_done_b !== 1'b0) begin errors++; $display("FAIL nl_e32_done got %b exp 0", seq_done_b); end
        tick(1);
        checks++; if (rst_n_out_b !== 3'b111) begin errors++; $display("FAIL nl_e33_rst got %b exp 111", rst_n_out_b); end
        checks++; if (seq_done_b !== 1'b1) begin errors++; $display("FAIL nl_e33_done got %b exp 1", seq_done_b); end
        checks++; if (lock_lost_b !== 3'b000) begin errors++; $display("FAIL nl_e33_lost got %b exp 000", lock_lost_b); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_wait_lock();
        test_lock_drop();
        test_sw_restart();
        test_back_to_back();
        test_lost_vs_clear();
        test_async_reset();
        test_no_lock_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
